// File: rtl/store_commit_queue_pkg.sv
// store_commit_queue_pkg
// Shared definitions for the store commit queue: drain FSM state encoding
// and the word-address LSB used by the queue, the load unit and the cache.
package store_commit_queue_pkg;

  localparam logic [0:0] SQ_IDLE  = 1'b0;
  localparam logic [0:0] SQ_WRITE = 1'b1;

  // Byte-address bits below this index select a byte within a word.
  localparam int WORD_LSB = 2;

endpackage

// File: rtl/store_commit_queue_if.sv
// store_commit_queue_if
// Bundles the three buses around the store commit queue:
//   commit side  : commitValid/commitAddr/commitData in, commitReady out
//   cache side   : cacheWriteEnable/Addr/Data out, cacheWriteDone in
//   forward side : loadAddr in, fwdHit/fwdData out
//   status       : count, drained out
// Modport slave is the queue itself; master is its environment.
interface store_commit_queue_if #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                       commitValid;
  logic [ADDR_W-1:0]          commitAddr;
  logic [DATA_W-1:0]          commitData;
  logic                       commitReady;
  logic                       cacheWriteEnable;
  logic [ADDR_W-1:0]          cacheWriteAddr;
  logic [DATA_W-1:0]          cacheWriteData;
  logic                       cacheWriteDone;
  logic [ADDR_W-1:0]          loadAddr;
  logic                       fwdHit;
  logic [DATA_W-1:0]          fwdData;
  logic [$clog2(DEPTH+1)-1:0] count;
  logic                       drained;

  modport slave (
    input  commitValid, commitAddr, commitData, cacheWriteDone, loadAddr,
    output commitReady, cacheWriteEnable, cacheWriteAddr, cacheWriteData,
           fwdHit, fwdData, count, drained
  );

  modport master (
    output commitValid, commitAddr, commitData, cacheWriteDone, loadAddr,
    input  commitReady, cacheWriteEnable, cacheWriteAddr, cacheWriteData,
           fwdHit, fwdData, count, drained
  );
endinterface

// File: rtl/store_commit_queue_fwd.sv
// sq_forward_match
// Store-to-load forwarding selector. Compares every valid entry against
// loadAddr on word address and returns the data of the youngest match.
// Ports: valid/addr/data per entry, head (oldest entry index), loadAddr;
//        hit and hitData out (hitData is 0 when there is no hit).
module sq_forward_match
  import store_commit_queue_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]             valid,
  input  logic [DEPTH-1:0][ADDR_W-1:0] addr,
  input  logic [DEPTH-1:0][DATA_W-1:0] data,
  input  logic [PTR_W-1:0]             head,
  input  logic [ADDR_W-1:0]            loadAddr,
  output logic                         hit,
  output logic [DATA_W-1:0]            hitData
);

  logic [PTR_W-1:0] idx;

  // Walk from oldest (head) to youngest; a later match overrides an earlier
  // one, so the entry closest to tail wins. Index wraps as DEPTH is 2^n.
  always_comb begin
    hit     = 1'b0;
    hitData = '0;
    idx     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PTR_W'(i);
      if (valid[idx] &&
          (addr[idx][ADDR_W-1:WORD_LSB] == loadAddr[ADDR_W-1:WORD_LSB])) begin
        hit     = 1'b1;
        hitData = data[idx];
      end
    end
  end

endmodule

// File: rtl/store_commit_queue.sv
// store_commit_queue
// Buffers stores retired by the ROB and drains them in program order to the
// data cache write port; also forwards committed-but-unwritten store data.
// Ports: clock, reset (async, active low), bus (store_commit_queue_if.slave).
module store_commit_queue
  import store_commit_queue_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clock,
  input  logic                reset,
  store_commit_queue_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0]             head;
  logic [PTR_W-1:0]             tail;
  logic [CNT_W-1:0]             cnt;
  logic [0:0]                   state;
  logic [DEPTH-1:0]             valid;
  logic [DEPTH-1:0]             valid_nxt;
  logic [DEPTH-1:0][ADDR_W-1:0] mem_addr;
  logic [DEPTH-1:0][DATA_W-1:0] mem_data;
  logic                         ready;
  logic                         push;
  logic                         pop;
  logic                         fwd_hit;
  logic [DATA_W-1:0]            fwd_data;

  assign ready = (cnt != CNT_W'(DEPTH));
  assign push  = bus.commitValid && ready;
  // Done outside WRITE is ignored.
  assign pop   = (state == SQ_WRITE) && bus.cacheWriteDone;

  always_comb begin
    valid_nxt = valid;
    if (pop)  valid_nxt[head] = 1'b0;
    if (push) valid_nxt[tail] = 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= SQ_IDLE;
      head  <= '0;
      tail  <= '0;
      cnt   <= '0;
      valid <= '0;
    end else begin
      valid <= valid_nxt;
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      if (push && !pop)      cnt <= cnt + 1'b1;
      else if (pop && !push) cnt <= cnt - 1'b1;
      case (state)
        SQ_IDLE:  if (cnt != '0) state <= SQ_WRITE;
        SQ_WRITE: if (bus.cacheWriteDone) state <= SQ_IDLE;
        default:  state <= SQ_IDLE;
      endcase
    end
  end

  // Payload storage needs no reset: valid bits and the WRITE-state gating
  // below keep stale contents from ever reaching an output. Push can never
  // target head during WRITE because the queue would then be full.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_addr[tail] <= bus.commitAddr;
      mem_data[tail] <= bus.commitData;
    end
  end

  sq_forward_match #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_fwd (
    .valid    (valid),
    .addr     (mem_addr),
    .data     (mem_data),
    .head     (head),
    .loadAddr (bus.loadAddr),
    .hit      (fwd_hit),
    .hitData  (fwd_data)
  );

  assign bus.commitReady      = ready;
  assign bus.cacheWriteEnable = (state == SQ_WRITE);
  assign bus.cacheWriteAddr   = (state == SQ_WRITE) ? mem_addr[head] : '0;
  assign bus.cacheWriteData   = (state == SQ_WRITE) ? mem_data[head] : '0;
  assign bus.fwdHit           = fwd_hit;
  assign bus.fwdData          = fwd_data;
  assign bus.count            = cnt;
  assign bus.drained          = (cnt == '0) && (state == SQ_IDLE);

endmodule

// File: tb/tb_store_commit_queue.sv
// tb_store_commit_queue
// Directed bench for store_commit_queue (DEPTH=4, 32-bit address/data).
module tb_store_commit_queue;

  logic clock;
  logic reset;
  int   total;
  int   passed;

  store_commit_queue_if #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) bus ();

  store_commit_queue #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s did not match", tag);
    end
  endtask

  task automatic wait_req(input string tag);
    int n;
    n = 0;
    while (!bus.cacheWriteEnable && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_req_seen"}, 64'(bus.cacheWriteEnable), 64'd1);
  endtask

  task automatic drain_one(input string tag, input logic [31:0] a, input logic [31:0] d);
    wait_req(tag);
    chk({tag, "_addr"}, 64'(bus.cacheWriteAddr), 64'(a));
    chk({tag, "_data"}, 64'(bus.cacheWriteData), 64'(d));
    bus.cacheWriteDone = 1'b1;
    tick();
    bus.cacheWriteDone = 1'b0;
    chk({tag, "_en_low_after_done"}, 64'(bus.cacheWriteEnable), 64'd0);
  endtask

  initial begin
    int sent;
    int wr;
    total  = 0;
    passed = 0;
    reset  = 1'b0;
    bus.commitValid    = 1'b0;
    bus.commitAddr     = '0;
    bus.commitData     = '0;
    bus.cacheWriteDone = 1'b0;
    bus.loadAddr       = '0;

    // Reset values
    tick();
    tick();
    chk("rst_ready",   64'(bus.commitReady), 64'd1);
    chk("rst_en",      64'(bus.cacheWriteEnable), 64'd0);
    chk("rst_waddr",   64'(bus.cacheWriteAddr), 64'd0);
    chk("rst_wdata",   64'(bus.cacheWriteData), 64'd0);
    chk("rst_fwdhit",  64'(bus.fwdHit), 64'd0);
    chk("rst_fwddata", 64'(bus.fwdData), 64'd0);
    chk("rst_count",   64'(bus.count), 64'd0);
    chk("rst_drained", 64'(bus.drained), 64'd1);
    reset = 1'b1;
    tick();

    // Single store: commit -> request two cycles later -> done -> drained
    bus.commitValid = 1'b1;
    bus.commitAddr  = 32'h40;
    bus.commitData  = 32'hDEADBEEF;
    tick();
    bus.commitValid = 1'b0;
    chk("t1_count_n1", 64'(bus.count), 64'd1);
    chk("t1_en_n1",    64'(bus.cacheWriteEnable), 64'd0);
    tick();
    chk("t1_en_n2",    64'(bus.cacheWriteEnable), 64'd1);
    chk("t1_addr",     64'(bus.cacheWriteAddr), 64'h40);
    chk("t1_data",     64'(bus.cacheWriteData), 64'hDEADBEEF);
    chk("t1_drained0", 64'(bus.drained), 64'd0);
    bus.loadAddr = 32'h43;
    #1;
    chk("t1_fwd_inflight_hit",  64'(bus.fwdHit), 64'd1);
    chk("t1_fwd_inflight_data", 64'(bus.fwdData), 64'hDEADBEEF);
    tick();
    chk("t1_en_held", 64'(bus.cacheWriteEnable), 64'd1);
    bus.cacheWriteDone = 1'b1;
    tick();
    bus.cacheWriteDone = 1'b0;
    chk("t1_count_after", 64'(bus.count), 64'd0);
    chk("t1_drained",     64'(bus.drained), 64'd1);
    chk("t1_en_after",    64'(bus.cacheWriteEnable), 64'd0);

    // Fill to DEPTH with done withheld; a commit while full is ignored
    for (int k = 0; k < 4; k++) begin
      bus.commitValid = 1'b1;
      bus.commitAddr  = 32'h100 + 32'(4 * k);
      bus.commitData  = 32'h1000 + 32'(k);
      tick();
    end
    chk("t2_count_full", 64'(bus.count), 64'd4);
    chk("t2_ready_full", 64'(bus.commitReady), 64'd0);
    // Deliberate protocol violation: commit presented while not ready.
    bus.commitAddr = 32'h200;
    bus.commitData = 32'hBAD;
    tick();
    bus.commitValid = 1'b0;
    chk("t2_count_ignored", 64'(bus.count), 64'd4);
    bus.loadAddr = 32'h200;
    #1;
    chk("t2_ignored_not_fwd", 64'(bus.fwdHit), 64'd0);
    drain_one("t2_w0", 32'h100, 32'h1000);
    chk("t2_count_3",  64'(bus.count), 64'd3);
    chk("t2_ready_back", 64'(bus.commitReady), 64'd1);
    drain_one("t2_w1", 32'h104, 32'h1001);
    drain_one("t2_w2", 32'h108, 32'h1002);
    drain_one("t2_w3", 32'h10C, 32'h1003);
    chk("t2_drained", 64'(bus.drained), 64'd1);

    // Ten stores streamed through with pointer wrap, done delayed at times
    sent = 0;
    wr   = 0;
    for (int c = 0; c < 400 && wr < 10; c++) begin
      bus.commitValid = (sent < 10) && bus.commitReady;
      if (bus.commitValid) begin
        bus.commitAddr = 32'h300 + 32'(4 * sent);
        bus.commitData = 32'hA000 + 32'(sent);
        sent++;
      end
      bus.cacheWriteDone = bus.cacheWriteEnable && ((c % 3) == 2);
      if (bus.cacheWriteDone) begin
        chk("t3_order_addr", 64'(bus.cacheWriteAddr), 64'(32'h300 + 32'(4 * wr)));
        chk("t3_order_data", 64'(bus.cacheWriteData), 64'(32'hA000 + 32'(wr)));
        wr++;
      end
      tick();
    end
    bus.commitValid    = 1'b0;
    bus.cacheWriteDone = 1'b0;
    chk("t3_all_written", 64'(wr), 64'd10);
    chk("t3_drained",     64'(bus.drained), 64'd1);

    // Forwarding: youngest match wins, word-address compare
    bus.commitValid = 1'b1;
    bus.commitAddr = 32'h80; bus.commitData = 32'd1; tick();
    bus.commitAddr = 32'h80; bus.commitData = 32'd2; tick();
    bus.commitAddr = 32'h84; bus.commitData = 32'd3; tick();
    bus.commitValid = 1'b0;
    bus.loadAddr = 32'h82;
    #1;
    chk("t4_hit_82",  64'(bus.fwdHit), 64'd1);
    chk("t4_data_82", 64'(bus.fwdData), 64'd2);
    bus.loadAddr = 32'h84;
    #1;
    chk("t4_data_84", 64'(bus.fwdData), 64'd3);
    bus.loadAddr = 32'h88;
    #1;
    chk("t4_hit_88",  64'(bus.fwdHit), 64'd0);
    chk("t4_data_88", 64'(bus.fwdData), 64'd0);
    drain_one("t4_w0", 32'h80, 32'd1);
    drain_one("t4_w1", 32'h80, 32'd2);
    drain_one("t4_w2", 32'h84, 32'd3);

    // Simultaneous push and pop at count 2
    bus.commitValid = 1'b1;
    bus.commitAddr = 32'h500; bus.commitData = 32'h51; tick();
    bus.commitAddr = 32'h504; bus.commitData = 32'h52; tick();
    bus.commitValid = 1'b0;
    wait_req("t5");
    chk("t5_count_before", 64'(bus.count), 64'd2);
    chk("t5_head_addr",    64'(bus.cacheWriteAddr), 64'h500);
    bus.commitValid    = 1'b1;
    bus.commitAddr     = 32'h508;
    bus.commitData     = 32'h53;
    bus.cacheWriteDone = 1'b1;
    tick();
    bus.commitValid    = 1'b0;
    bus.cacheWriteDone = 1'b0;
    chk("t5_count_same", 64'(bus.count), 64'd2);
    drain_one("t5_next", 32'h504, 32'h52);
    drain_one("t5_last", 32'h508, 32'h53);

    // Reset asserted mid-write
    bus.commitValid = 1'b1;
    bus.commitAddr  = 32'h600;
    bus.commitData  = 32'h61;
    tick();
    bus.commitValid = 1'b0;
    wait_req("t6");
    reset = 1'b0;
    #1;
    chk("t6_en_dropped", 64'(bus.cacheWriteEnable), 64'd0);
    chk("t6_count",      64'(bus.count), 64'd0);
    chk("t6_drained",    64'(bus.drained), 64'd1);
    tick();
    reset = 1'b1;
    bus.cacheWriteDone = 1'b1;
    tick();
    tick();
    bus.cacheWriteDone = 1'b0;
    tick();
    chk("t6_done_ignored_count", 64'(bus.count), 64'd0);
    chk("t6_done_ignored_en",    64'(bus.cacheWriteEnable), 64'd0);
    chk("t6_done_ignored_drn",   64'(bus.drained), 64'd1);
    chk("t6_ready",              64'(bus.commitReady), 64'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
